// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line/clock rates and
// the bit-timing derivations used by both the receive and transmit paths.
package uart_pkg;

  localparam int unsigned DefaultClockFreq = 50_000_000;
  localparam int unsigned DefaultBaudRate  = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit; integer division truncates, which is the intended rounding.
  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned sample_time(input int unsigned clock_freq,
                                              input int unsigned baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is a
// parameter so an idle-high line does not look like a falling edge after reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: flops use non-blocking assignments so each stage samples the value
  // from before the edge; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver presenting bytes on a DataOut/DataOutValid/DataOutReady
// handshake. Define UART_RX_FRAMING_ERR_EN to add the FrameError pulse output.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned ClockFreq = DefaultClockFreq,
  parameter int unsigned BaudRate  = DefaultBaudRate
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       Overrun
`ifdef UART_RX_FRAMING_ERR_EN
  ,
  output logic       FrameError
`endif
);

  localparam int unsigned SymbolEdgeTime = symbol_edge_time(ClockFreq, BaudRate);
  localparam int unsigned SampleTime     = sample_time(ClockFreq, BaudRate);
  localparam int unsigned CntW           = $clog2(SymbolEdgeTime);
  localparam logic [CntW-1:0] SampleCnt  = CntW'(SampleTime);
  localparam logic [CntW-1:0] LastCnt    = CntW'(SymbolEdgeTime - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (Clock),
    .rst_n (Reset),
    .d     (SIn),
    .q     (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_prev_q;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            sample_stb;
  logic            frame_ok;

  assign sample_stb = (cnt_q == SampleCnt);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    frame_ok  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (sample_stb) begin
          state_d   = rx_s ? IDLE : DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (sample_stb) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (sample_stb) begin
          state_d  = IDLE;
          frame_ok = rx_s;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter is pinned to 0 while idle so START always begins a fresh bit period.
    if (state_q == IDLE || state_d == IDLE) cnt_d = '0;
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && DataOutReady) valid_d = 1'b0;
    // A completing frame wins over a same-cycle transfer; it only counts as
    // an overrun when the pending byte was not taken this cycle.
    if (frame_ok) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !DataOutReady) overrun_d = 1'b1;
    end
  end

  // NOTE: the shift register and data byte are reset too; they are plain flops,
  // not a memory, and DataOut must read 0 immediately on reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_prev_q <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_prev_q <= rx_s;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign DataOut      = data_q;
  assign DataOutValid = valid_q;
  assign Overrun      = overrun_q;

`ifdef UART_RX_FRAMING_ERR_EN
  logic frame_err_q, frame_err_d;

  assign frame_err_d = sample_stb &&
                       ((state_q == START && rx_s) || (state_q == STOP && !rx_s));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign FrameError = frame_err_q;
`endif

endmodule
